// File: rtl/div_seq_unit_if.sv
// EX <-> divider handshake bundle: operation request, result return and flush.
// The master modport is the EX stage; the slave modport is the divider.
interface div_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             div_in_valid;
    logic             div_in_ready;
    logic             div_signed;
    logic [WIDTH-1:0] div_src1;
    logic [WIDTH-1:0] div_src2;
    logic             div_out_valid;
    logic             div_out_ready;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             div_busy;

    modport master (
        output flush, div_in_valid, div_signed, div_src1, div_src2, div_out_ready,
        input  div_in_ready, div_out_valid, div_quotient, div_remainder, div_busy
    );

    modport slave (
        input  flush, div_in_valid, div_signed, div_src1, div_src2, div_out_ready,
        output div_in_ready, div_out_valid, div_quotient, div_remainder, div_busy
    );
endinterface

// File: rtl/div_seq_unit.sv
// Sequential restoring divider for div.w/mod.w/div.wu/mod.wu.
// It produces one quotient bit per cycle and presents a signed result after WIDTH CALC cycles.
module div_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          resetn,
    div_seq_unit_if.slave io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic             sign_q;
        logic             sign_r;
        logic             dz;
        logic [WIDTH-1:0] src1_raw;
        logic [WIDTH-1:0] dvs_mag;
    } op_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    op_t              op;
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] partial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last;

    assign a_neg = io.div_signed & io.div_src1[WIDTH-1];
    assign b_neg = io.div_signed & io.div_src2[WIDTH-1];
    assign a_mag = a_neg ? -io.div_src1 : io.div_src1;
    assign b_mag = b_neg ? -io.div_src2 : io.div_src2;

    // The dividend is shifted out MSB first, so its top bit is the next bit to bring down.
    assign partial = {rem[WIDTH-2:0], dvd_sh[WIDTH-1]};
    assign diff    = {1'b0, partial} - {1'b0, op.dvs_mag};
    assign ge      = ~diff[WIDTH];
    assign rem_nxt = ge ? diff[WIDTH-1:0] : partial;
    assign q_nxt   = {q[WIDTH-2:0], ge};
    assign last    = (cnt == CNT_W'(WIDTH-1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            dvd_sh <= '0;
            rem    <= '0;
            q      <= '0;
            quo_r  <= '0;
            rem_r  <= '0;
        end else if (io.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (io.div_in_valid) begin
                        op.sign_q   <= a_neg ^ b_neg;
                        op.sign_r   <= a_neg;
                        op.dz       <= (io.div_src2 == '0);
                        op.src1_raw <= io.div_src1;
                        op.dvs_mag  <= b_mag;
                        dvd_sh      <= a_mag;
                        rem         <= '0;
                        q           <= '0;
                        cnt         <= '0;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
                    rem    <= rem_nxt;
                    q      <= q_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        // Divide-by-zero overrides the sign fixup: all-ones quotient, raw dividend.
                        quo_r <= op.dz ? '1 : (op.sign_q ? -q_nxt : q_nxt);
                        rem_r <= op.dz ? op.src1_raw : (op.sign_r ? -rem_nxt : rem_nxt);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (io.div_out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.div_in_ready  = (state == IDLE);
    assign io.div_busy      = (state != IDLE);
    assign io.div_out_valid = (state == DONE);
    assign io.div_quotient  = quo_r;
    assign io.div_remainder = rem_r;

endmodule
